// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl_if.sv
// ad_ip_jesd204_tpl_dac_start_ctrl_if: register-map command/status and link-side signals of the DAC start sequencer
interface ad_ip_jesd204_tpl_dac_start_ctrl_if #(
  parameter int TIMEOUT_W = 16
);
  logic                 cfg_arm;
  logic                 cfg_disarm;
  logic                 cfg_ext_sync_en;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 ext_sync;
  logic                 link_ready;
  logic                 dac_sync;
  logic                 dac_data_gate;
  logic [1:0]           status_state;
  logic                 status_link_lost;
  logic                 status_timeout;
  logic [7:0]           status_sync_cnt;
  modport master (
    output cfg_arm, cfg_disarm, cfg_ext_sync_en, cfg_timeout, ext_sync, link_ready,
    input  dac_sync, dac_data_gate, status_state, status_link_lost, status_timeout, status_sync_cnt
  );
  modport slave (
    input  cfg_arm, cfg_disarm, cfg_ext_sync_en, cfg_timeout, ext_sync, link_ready,
    output dac_sync, dac_data_gate, status_state, status_link_lost, status_timeout, status_sync_cnt
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// ad_ip_jesd204_tpl_dac_start_ctrl: arm/sync/run sequencer gating TPL DAC data onto a stable link
// Define DAC_START_CTRL_TIMEOUT_EN to enable the ARMED-state timeout.
module ad_ip_jesd204_tpl_dac_start_ctrl #(
  parameter int SYNC_PULSE_LEN = 4,
  parameter int READY_WAIT     = 16,
  parameter int TIMEOUT_W      = 16
) (
  input logic clk,
  input logic reset,
  ad_ip_jesd204_tpl_dac_start_ctrl_if.slave bus
);
  localparam int PW = $clog2(SYNC_PULSE_LEN + 1);
  typedef enum logic [1:0] {IDLE, ARMED, SYNC, RUN} state_t;
  state_t state, nxt;
  logic [7:0] rdy_cnt;
  logic [PW-1:0] pcnt;
  logic ext_sync_d;
  logic ready_ok, trigger, timeout;
  assign ready_ok = bus.link_ready && rdy_cnt == 8'(READY_WAIT);
  assign trigger = ready_ok && (bus.cfg_ext_sync_en ? bus.ext_sync && !ext_sync_d : 1'b1);
  assign bus.status_state = state;
`ifdef DAC_START_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  logic to_flag;
  assign timeout = state == ARMED && bus.cfg_timeout != '0 && tcnt + TIMEOUT_W'(1) == bus.cfg_timeout;
  assign bus.status_timeout = to_flag;
  always_ff @(posedge clk)
    if (reset) begin
      tcnt <= '0;
      to_flag <= 1'b0;
    end else begin
      tcnt <= state == ARMED ? tcnt + TIMEOUT_W'(1) : '0;
      to_flag <= (timeout && !trigger && !bus.cfg_disarm) ? 1'b1 :
                 (bus.cfg_arm && state != RUN) ? 1'b0 : to_flag;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^bus.cfg_timeout;
  assign timeout = 1'b0;
  assign bus.status_timeout = 1'b0;
`endif
  // Disarm beats everything; a link drop in SYNC or RUN falls back to ARMED for auto re-arm.
  always_comb
    nxt = bus.cfg_disarm ? IDLE :
          state == IDLE  ? (bus.cfg_arm ? ARMED : IDLE) :
          state == ARMED ? (trigger ? SYNC : timeout ? IDLE : ARMED) :
          !bus.link_ready ? ARMED :
          (state == SYNC && pcnt == PW'(SYNC_PULSE_LEN - 1)) ? RUN : state;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.dac_sync <= 1'b1;
      bus.dac_data_gate <= 1'b0;
      bus.status_link_lost <= 1'b0;
      bus.status_sync_cnt <= 8'd0;
      rdy_cnt <= 8'd0;
      pcnt <= '0;
      ext_sync_d <= 1'b1;
    end else begin
      state <= nxt;
      bus.dac_sync <= nxt != RUN;
      bus.dac_data_gate <= nxt == RUN;
      ext_sync_d <= bus.ext_sync;
      rdy_cnt <= !bus.link_ready ? 8'd0 : ready_ok ? rdy_cnt : rdy_cnt + 8'd1;
      pcnt <= state == SYNC ? pcnt + PW'(1) : '0;
      if (state == ARMED && nxt == SYNC)
        bus.status_sync_cnt <= bus.status_sync_cnt + 8'd1;
      bus.status_link_lost <= (state == RUN && !bus.link_ready) ? 1'b1 :
                              (bus.cfg_arm && state != RUN) ? 1'b0 : bus.status_link_lost;
    end
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
// tb_ad_ip_jesd204_tpl_dac_start_ctrl: directed self-checking bench for the DAC start sequencer
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_err = 0;
  ad_ip_jesd204_tpl_dac_start_ctrl_if #(.TIMEOUT_W(16)) bus ();
  ad_ip_jesd204_tpl_dac_start_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic arm();
    bus.cfg_arm = 1'b1;
    step(1);
    bus.cfg_arm = 1'b0;
  endtask
  task automatic disarm();
    bus.cfg_disarm = 1'b1;
    step(1);
    bus.cfg_disarm = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(bus.status_state), 0);
    check({tag, "_dac_sync"}, 32'(bus.dac_sync), 1);
    check({tag, "_gate"}, 32'(bus.dac_data_gate), 0);
    check({tag, "_lost"}, 32'(bus.status_link_lost), 0);
    check({tag, "_tmo"}, 32'(bus.status_timeout), 0);
    check({tag, "_cnt"}, 32'(bus.status_sync_cnt), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.cfg_arm = 1'b0;
    bus.cfg_disarm = 1'b0;
    bus.cfg_ext_sync_en = 1'b0;
    bus.cfg_timeout = '0;
    bus.ext_sync = 1'b0;
    bus.link_ready = 1'b0;
    step(2);
    check_reset("rst");
    reset = 1'b0;
    arm();
    check("t1_armed", 32'(bus.status_state), 1);
    bus.link_ready = 1'b1;
    step(16);
    check("t1_wait16", 32'(bus.status_state), 1);
    step(1);
    check("t1_sync", 32'(bus.status_state), 2);
    check("t1_sync_ds", 32'(bus.dac_sync), 1);
    check("t1_sync_gate", 32'(bus.dac_data_gate), 0);
    check("t1_cnt", 32'(bus.status_sync_cnt), 1);
    step(3);
    check("t1_sync4", 32'(bus.status_state), 2);
    check("t1_sync4_ds", 32'(bus.dac_sync), 1);
    step(1);
    check("t1_run", 32'(bus.status_state), 3);
    check("t1_run_ds", 32'(bus.dac_sync), 0);
    check("t1_run_gate", 32'(bus.dac_data_gate), 1);
    bus.link_ready = 1'b0;
    step(1);
    bus.link_ready = 1'b1;
    check("t3_drop_state", 32'(bus.status_state), 1);
    check("t3_drop_gate", 32'(bus.dac_data_gate), 0);
    check("t3_drop_ds", 32'(bus.dac_sync), 1);
    check("t3_lost", 32'(bus.status_link_lost), 1);
    step(16);
    check("t3_wait16", 32'(bus.status_state), 1);
    step(1);
    check("t3_resync", 32'(bus.status_state), 2);
    check("t3_cnt", 32'(bus.status_sync_cnt), 2);
    step(4);
    check("t3_run", 32'(bus.status_state), 3);
    arm();
    check("t3_arm_in_run", 32'(bus.status_state), 3);
    check("t3_lost_kept", 32'(bus.status_link_lost), 1);
    disarm();
    check("t3_disarm", 32'(bus.status_state), 0);
    arm();
    check("t3_rearm", 32'(bus.status_state), 1);
    check("t3_lost_clr", 32'(bus.status_link_lost), 0);
    step(1);
    check("t3_fast_sync", 32'(bus.status_state), 2);
    check("t3_cnt3", 32'(bus.status_sync_cnt), 3);
    disarm();
    check("t4_disarm_sync", 32'(bus.status_state), 0);
    check("t4_disarm_ds", 32'(bus.dac_sync), 1);
    bus.cfg_disarm = 1'b1;
    arm();
    bus.cfg_disarm = 1'b0;
    check("t4_arm_disarm", 32'(bus.status_state), 0);
    bus.cfg_ext_sync_en = 1'b1;
    bus.ext_sync = 1'b1;
    step(1);
    bus.ext_sync = 1'b0;
    step(1);
    arm();
    step(3);
    check("t2_pre_edge", 32'(bus.status_state), 1);
    bus.ext_sync = 1'b1;
    step(1);
    check("t2_post_edge", 32'(bus.status_state), 2);
    check("t2_cnt4", 32'(bus.status_sync_cnt), 4);
    step(4);
    check("t2_run", 32'(bus.status_state), 3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_reset("t6_rst_run");
    arm();
    step(20);
    check("t2_high_rst", 32'(bus.status_state), 1);
    bus.link_ready = 1'b0;
    bus.ext_sync = 1'b0;
    step(1);
    bus.ext_sync = 1'b1;
    step(1);
    bus.link_ready = 1'b1;
    step(20);
    check("t2_edge_dropped", 32'(bus.status_state), 1);
    bus.ext_sync = 1'b0;
    step(1);
    bus.ext_sync = 1'b1;
    step(1);
    bus.ext_sync = 1'b0;
    check("t2_edge_ok", 32'(bus.status_state), 2);
    check("t2_cnt1", 32'(bus.status_sync_cnt), 1);
    disarm();
`ifdef DAC_START_CTRL_TIMEOUT_EN
    bus.cfg_timeout = 16'd100;
    arm();
    step(99);
    check("t5_before_tmo", 32'(bus.status_state), 1);
    step(1);
    check("t5_tmo_state", 32'(bus.status_state), 0);
    check("t5_tmo_flag", 32'(bus.status_timeout), 1);
    arm();
    check("t5_tmo_clr", 32'(bus.status_timeout), 0);
    step(98);
    bus.ext_sync = 1'b1;
    step(1);
    bus.ext_sync = 1'b0;
    check("t5_trig_wins", 32'(bus.status_state), 2);
    check("t5_trig_noflag", 32'(bus.status_timeout), 0);
    disarm();
`else
    bus.cfg_timeout = 16'd100;
    arm();
    step(10000);
    check("t5_hold", 32'(bus.status_state), 1);
    check("t5_no_tmo", 32'(bus.status_timeout), 0);
    disarm();
`endif
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus.cfg_ext_sync_en = 1'b0;
    step(17);
    for (int i = 0; i < 256; i++) begin
      arm();
      step(1);
      disarm();
      if (i == 254) check("t6_cnt255", 32'(bus.status_sync_cnt), 255);
    end
    check("t6_wrap", 32'(bus.status_sync_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
